// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/state types and instruction field positions for cpu_control
package cpu_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
    OP_LDI, OP_MOV, OP_JMP, OP_BEQZ, OP_ILLC, OP_ILLD, OP_ILLE, OP_HALT
  } opcode_t;
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} ctrl_state_t;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  localparam logic [15:0] NOP = 16'h0000;
endpackage

// File: rtl/cpu_decoder.sv
// cpu_decoder: opcode -> control strobes. CPU_CTRL_BRANCH_EN enables BEQZ, else opcode B is illegal.
module cpu_decoder
  import cpu_pkg::*;
(
  input  opcode_t op,
  output logic    we,
  output logic    imm_sel,
  output logic    is_jmp,
  output logic    is_beqz,
  output logic    illegal,
  output logic    updates_zf
);
  always_comb begin
    we         = (op >= OP_ADD) && (op <= OP_MOV);
    imm_sel    = op == OP_LDI;
    is_jmp     = op == OP_JMP;
`ifdef CPU_CTRL_BRANCH_EN
    is_beqz    = op == OP_BEQZ;
    illegal    = (op >= OP_ILLC) && (op <= OP_ILLE);
`else
    is_beqz    = 1'b0;
    illegal    = (op >= OP_BEQZ) && (op <= OP_ILLE);
`endif
    updates_zf = we && (op != OP_LDI);
  end
endmodule

// File: rtl/cpu_control.sv
// cpu_control: 3-cycle fetch/decode/execute sequencer driving the register file and ALU.
// Define CPU_CTRL_BRANCH_EN to implement BEQZ; otherwise opcode B decodes as illegal.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               alu_zero,
  output logic [3:0]         RA1,
  output logic [3:0]         RA2,
  output logic [3:0]         WA,
  output logic               write_enable,
  output logic [3:0]         alu_op,
  output logic               imm_sel,
  output logic [7:0]         imm,
  output logic               halted,
  output logic               illegal
);
  ctrl_state_t        state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               zf_q, zf_d;
  opcode_t            op;
  logic               dec_we, dec_imm_sel, is_jmp, is_beqz, dec_illegal, updates_zf;
  logic               exec, halt_op, taken;
  assign op = opcode_t'(ir_q[OPC_MSB:OPC_LSB]);
  cpu_decoder u_dec (
    .op         (op),
    .we         (dec_we),
    .imm_sel    (dec_imm_sel),
    .is_jmp     (is_jmp),
    .is_beqz    (is_beqz),
    .illegal    (dec_illegal),
    .updates_zf (updates_zf)
  );
  always_comb begin
    exec         = state_q == S_EXECUTE;
    halt_op      = op == OP_HALT;
    taken        = is_jmp || (is_beqz && zf_q);
    state_d      = state_q == S_FETCH ? S_DECODE :
                   state_q == S_DECODE ? S_EXECUTE :
                   (exec && !halt_op) ? S_FETCH : S_HALT;
    ir_d         = state_q == S_DECODE ? instr_data : ir_q;
    pc_d         = (!exec || halt_op) ? pc_q :
                   taken ? PC_W'(ir_q[IMM_MSB:IMM_LSB]) : pc_q + PC_W'(1);
    zf_d         = (exec && updates_zf) ? alu_zero : zf_q;
    pc           = pc_q;
    RA1          = ir_q[RS1_MSB:RS1_LSB];
    RA2          = ir_q[RS2_MSB:RS2_LSB];
    WA           = ir_q[RD_MSB:RD_LSB];
    imm          = ir_q[IMM_MSB:IMM_LSB];
    // reset must kill a write already in its EXECUTE cycle
    write_enable = exec && dec_we && !RST;
    alu_op       = exec ? ir_q[OPC_MSB:OPC_LSB] : 4'h0;
    imm_sel      = dec_imm_sel;
    halted       = state_q == S_HALT;
    illegal      = exec && dec_illegal;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= INSTR_W'(NOP);
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zf_q    <= zf_d;
    end
  end
endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: directed instruction sequence against a synchronous ROM model.
module tb_cpu_control;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  pc;
  logic [15:0] instr_data = 16'h0000;
  logic        alu_zero = 1'b0;
  logic [3:0]  RA1, RA2, WA, alu_op;
  logic        write_enable, imm_sel, halted, illegal;
  logic [7:0]  imm;
  logic [15:0] rom [256];
  int          n_tests = 0;
  int          n_fail = 0;
  cpu_control dut (
    .CLK          (CLK),
    .RST          (RST),
    .pc           (pc),
    .instr_data   (instr_data),
    .alu_zero     (alu_zero),
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .write_enable (write_enable),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .imm          (imm),
    .halted       (halted),
    .illegal      (illegal)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) instr_data <= rom[pc];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // entered at the negedge of FETCH, returns at the negedge of the next FETCH
  task automatic exec_instr(input string tag, input logic az,
                            input logic [3:0] ewa, input logic [3:0] era1, input logic [3:0] era2,
                            input logic [3:0] eop, input logic [7:0] eimm,
                            input logic ewe, input logic eis, input logic eill, input logic [7:0] epc);
    check({tag, "_f_we"}, write_enable, 1'b0);
    @(negedge CLK);
    check({tag, "_d_we"}, write_enable, 1'b0);
    check({tag, "_d_op"}, alu_op, 4'h0);
    check({tag, "_d_ill"}, illegal, 1'b0);
    alu_zero = az;
    @(negedge CLK);
    check({tag, "_wa"}, WA, ewa);
    check({tag, "_ra1"}, RA1, era1);
    check({tag, "_ra2"}, RA2, era2);
    check({tag, "_op"}, alu_op, eop);
    check({tag, "_imm"}, imm, eimm);
    check({tag, "_we"}, write_enable, ewe);
    check({tag, "_isel"}, imm_sel, eis);
    check({tag, "_ill"}, illegal, eill);
    @(negedge CLK);
    check({tag, "_pc"}, pc, epc);
    check({tag, "_n_we"}, write_enable, 1'b0);
    check({tag, "_n_ill"}, illegal, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h8111;
    rom[8'h01] = 16'h1312;
    rom[8'h02] = 16'h2411;
    rom[8'h03] = 16'hB020;
    rom[8'h04] = 16'hA030;
    rom[8'h20] = 16'hA030;
    rom[8'h30] = 16'hD000;
    rom[8'h31] = 16'h2411;
    rom[8'h32] = 16'hB040;
    rom[8'h33] = 16'hA0FF;
    rom[8'hFF] = 16'h0000;
    repeat (2) @(negedge CLK);
    check("rst_we_held", write_enable, 1'b0);
    RST = 1'b0;
    check("rst_pc", pc, 8'h00);
    check("rst_halted", halted, 1'b0);
    check("rst_op", alu_op, 4'h0);
    check("rst_isel", imm_sel, 1'b0);
    check("rst_ill", illegal, 1'b0);
    exec_instr("ldi", 1'b0, 4'h1, 4'h1, 4'h1, 4'h8, 8'h11, 1'b1, 1'b1, 1'b0, 8'h01);
    exec_instr("add", 1'b0, 4'h3, 4'h1, 4'h2, 4'h1, 8'h12, 1'b1, 1'b0, 1'b0, 8'h02);
    exec_instr("sub_z", 1'b1, 4'h4, 4'h1, 4'h1, 4'h2, 8'h11, 1'b1, 1'b0, 1'b0, 8'h03);
`ifdef CPU_CTRL_BRANCH_EN
    exec_instr("beqz_t", 1'b0, 4'h0, 4'h2, 4'h0, 4'hB, 8'h20, 1'b0, 1'b0, 1'b0, 8'h20);
`else
    exec_instr("beqz_t", 1'b0, 4'h0, 4'h2, 4'h0, 4'hB, 8'h20, 1'b0, 1'b0, 1'b1, 8'h04);
`endif
    exec_instr("jmp30", 1'b0, 4'h0, 4'h3, 4'h0, 4'hA, 8'h30, 1'b0, 1'b0, 1'b0, 8'h30);
    exec_instr("illd", 1'b0, 4'h0, 4'h0, 4'h0, 4'hD, 8'h00, 1'b0, 1'b0, 1'b1, 8'h31);
    exec_instr("sub_nz", 1'b0, 4'h4, 4'h1, 4'h1, 4'h2, 8'h11, 1'b1, 1'b0, 1'b0, 8'h32);
`ifdef CPU_CTRL_BRANCH_EN
    exec_instr("beqz_nt", 1'b1, 4'h0, 4'h4, 4'h0, 4'hB, 8'h40, 1'b0, 1'b0, 1'b0, 8'h33);
`else
    exec_instr("beqz_nt", 1'b1, 4'h0, 4'h4, 4'h0, 4'hB, 8'h40, 1'b0, 1'b0, 1'b1, 8'h33);
`endif
    exec_instr("jmpff", 1'b0, 4'h0, 4'hF, 4'hF, 4'hA, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF);
    exec_instr("nop_wrap", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    exec_instr("ldi2", 1'b0, 4'h1, 4'h1, 4'h1, 4'h8, 8'h11, 1'b1, 1'b1, 1'b0, 8'h01);
    @(negedge CLK);
    @(negedge CLK);
    check("rstx_we_pre", write_enable, 1'b1);
    check("rstx_op_pre", alu_op, 4'h1);
    RST = 1'b1;
    #1;
    check("rstx_we_kill", write_enable, 1'b0);
    @(negedge CLK);
    check("rstx_pc", pc, 8'h00);
    check("rstx_op", alu_op, 4'h0);
    check("rstx_halted", halted, 1'b0);
    rom[8'h00] = 16'hA050;
    rom[8'h50] = 16'hF000;
    RST = 1'b0;
    exec_instr("jmp50", 1'b0, 4'h0, 4'h5, 4'h0, 4'hA, 8'h50, 1'b0, 1'b0, 1'b0, 8'h50);
    @(negedge CLK);
    @(negedge CLK);
    check("halt_x_halted", halted, 1'b0);
    check("halt_x_we", write_enable, 1'b0);
    check("halt_x_ill", illegal, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      check("halt_halted", halted, 1'b1);
      check("halt_pc", pc, 8'h50);
      check("halt_we", write_enable, 1'b0);
    end
    RST = 1'b1;
    @(negedge CLK);
    check("halt_rst_pc", pc, 8'h00);
    check("halt_rst_halted", halted, 1'b0);
    RST = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
